// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like master port between inst-fetch and data requesters.
// Round-robin address arbitration with grant lock; in-order source FIFO routes responses.
module sram_req_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             rr_ptr;
    logic             lock;
    logic             lock_src;
    logic             fifo [OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic grant;
    logic accept;
    logic pop;
    logic head;

    assign full  = (count == CNT_W'(OUTSTANDING));
    assign empty = (count == '0);

    // Lock holds the grant on a stalled requester until its address is taken.
    always_comb begin
        grant = 1'b0;
        if (lock)
            grant = lock_src;
        else if (inst_req && !data_req)
            grant = 1'b0;
        else if (data_req && !inst_req)
            grant = 1'b1;
        else if (inst_req && data_req)
            grant = rr_ptr;
    end

    always_comb begin
        m_req   = ~reset & ~full & (grant ? data_req : inst_req);
        m_wr    = grant ? data_wr    : inst_wr;
        m_size  = grant ? data_size  : inst_size;
        m_wstrb = grant ? data_wstrb : inst_wstrb;
        m_addr  = grant ? data_addr  : inst_addr;
        m_wdata = grant ? data_wdata : inst_wdata;
    end

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & ~grant;
    assign data_addr_ok = accept & grant;

    // Responses come back in issue order; the FIFO head names their owner.
    assign head         = fifo[rd_ptr];
    assign pop          = ~reset & m_data_ok & ~empty;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= 1'b1;
            lock     <= 1'b0;
            lock_src <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < int'(OUTSTANDING); i++)
                fifo[i] <= 1'b0;
        end else begin
            if (accept) begin
                fifo[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                rr_ptr       <= ~grant;
                lock         <= 1'b0;
            end else if (m_req) begin
                lock     <= 1'b1;
                lock_src <= grant;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !accept)
                count <= count - CNT_W'(1);
        end
    end

endmodule
